// File: rtl/lut_sweep_pkg.sv
// Shared types and helpers for the LUT sweep evaluator.
package lut_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of truth-table entries for a given number of logic inputs.
  function automatic int tt_size(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/lut_sweep_ctr.sv
// Wrapping index counter used to walk every truth-table entry during a sweep.
module lut_sweep_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         last
);

  assign last = &idx;

  // Advance on enable; the natural W-bit wrap brings the index back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + W'(1);
    end
  end

endmodule

// File: rtl/lut_sweep_eval.sv
// Serially loaded truth table with single-shot evaluation and exhaustive sweep.
//
// state | meaning
// IDLE  | accepts config shifts, single evaluations and sweep requests
// SWEEP | issues one table entry per cycle; index 0 goes out on the entry edge
// DONE  | one-cycle completion marker, then back to IDLE
module lut_sweep_eval
  import lut_sweep_pkg::*;
#(
  parameter int                         N_IN    = 3,
  parameter logic [tt_size(N_IN)-1:0]   TT_INIT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  input  logic            sweep_start,
  output logic            out_valid,
  output logic            out_bit,
  output logic [N_IN-1:0] out_index,
  output logic            busy,
  output logic            done
);

  localparam int TT_W = tt_size(N_IN);

  state_t            state;
  state_t            state_nxt;
  logic [TT_W-1:0]   tt;
  logic              issue;
  logic [N_IN-1:0]   issue_idx;
  logic              ctr_en;
  logic [N_IN-1:0]   ctr_idx;
  logic              ctr_last;
  logic              last_sent;

  lut_sweep_ctr #(.W(N_IN)) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ctr_en),
    .idx  (ctr_idx),
    .last (ctr_last)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and issue decision. The counter rests at 0 in IDLE, so the
  // entry edge into SWEEP can already issue index 0 and keep the stream
  // gap-free from the cycle after sweep_start.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    issue_idx = ctr_idx;
    ctr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (sweep_start) begin
          state_nxt = SWEEP;
          issue     = 1'b1;
          ctr_en    = 1'b1;
        end else if (in_valid) begin
          issue     = 1'b1;
          issue_idx = in_vec;
        end
      end
      SWEEP: begin
        if (last_sent) begin
          state_nxt = DONE;
        end else begin
          issue  = 1'b1;
          ctr_en = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Truth-table shifter: only loads while idle, cfg_bit enters at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt <= TT_INIT;
    end else if ((state == IDLE) && cfg_valid) begin
      tt <= {cfg_bit, tt[TT_W-1:1]};
    end
  end

  // Registered result; data holds its last value when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_index <= '0;
      last_sent <= 1'b0;
    end else begin
      out_valid <= issue;
      if (issue) begin
        out_bit   <= tt[issue_idx];
        out_index <= issue_idx;
      end
      last_sent <= ctr_en & ctr_last;
    end
  end

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Self-checking bench: scoreboard on the 3-input instance, inline checks on
// the 1- and 6-input instances.
module tb_lut_sweep_eval;

  localparam logic [7:0]  TT3_INIT = 8'hA5;
  localparam logic [1:0]  TT1_INIT = 2'b10;
  localparam logic [63:0] TT6_INIT = 64'h0123_4567_89AB_CDEF;

  typedef struct packed {
    logic [2:0] idx;
    logic       val;
  } exp_t;

  typedef struct {
    logic [2:0] vec;
    logic       exp_bit;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       cfg_valid, cfg_bit, in_valid, sweep_start;
  logic [2:0] in_vec;
  logic       out_valid, out_bit, busy, done;
  logic [2:0] out_index;

  logic       ss1, ov1, ob1, bz1, dn1;
  logic [0:0] oi1, iv1;
  logic       ss6, ov6, ob6, bz6, dn6;
  logic [5:0] oi6, iv6;
  logic       tie0;

  lut_sweep_eval #(.N_IN(3), .TT_INIT(TT3_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .in_valid(in_valid), .in_vec(in_vec), .sweep_start(sweep_start),
    .out_valid(out_valid), .out_bit(out_bit), .out_index(out_index),
    .busy(busy), .done(done)
  );

  lut_sweep_eval #(.N_IN(1), .TT_INIT(TT1_INIT)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(tie0), .cfg_bit(tie0),
    .in_valid(tie0), .in_vec(iv1), .sweep_start(ss1),
    .out_valid(ov1), .out_bit(ob1), .out_index(oi1),
    .busy(bz1), .done(dn1)
  );

  lut_sweep_eval #(.N_IN(6), .TT_INIT(TT6_INIT)) dut6 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(tie0), .cfg_bit(tie0),
    .in_valid(tie0), .in_vec(iv6), .sweep_start(ss6),
    .out_valid(ov6), .out_bit(ob6), .out_index(oi6),
    .busy(bz6), .done(dn6)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb[$];
  logic [7:0] tt_model;
  vec_t       tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every valid result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got index %0d bit %0d with nothing expected", out_index, out_bit);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_index", 64'(out_index), 64'(e.idx));
        check("sb_bit", 64'(out_bit), 64'(e.val));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eval(input logic [2:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    sb.push_back('{idx: v, val: tt_model[v]});
    tick();
    in_valid = 1'b0;
    check("eval_latency", 64'(out_valid), 64'd1);
  endtask

  task automatic shift_tt(input logic [7:0] bits_in_order);
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = bits_in_order[i];
      tt_model  = {bits_in_order[i], tt_model[7:1]};
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic sweep3(input logic with_eval, input logic cfg_toggle);
    sweep_start = 1'b1;
    in_valid    = with_eval;
    in_vec      = 3'd7;
    for (int i = 0; i < 8; i++) sb.push_back('{idx: 3'(i), val: tt_model[i]});
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cfg_valid = cfg_toggle && (c <= 9) && c[0];
      cfg_bit   = 1'b1;
      // These extra requests must be ignored while busy.
      sweep_start = (c == 4);
      in_valid    = (c == 9);
      @(negedge clk);
      check($sformatf("sweep_valid_c%0d", c), 64'(out_valid), 64'(c <= 8));
      check($sformatf("sweep_busy_c%0d", c), 64'(busy), 64'(c <= 9));
      check($sformatf("sweep_done_c%0d", c), 64'(done), 64'(c == 9));
      @(posedge clk);
      #1;
    end
    cfg_valid   = 1'b0;
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    check("sweep_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic sweep_small(input int n);
    int          n_valid, n_done, n_bad;
    logic        lv, lb, ld, lbz;
    logic [5:0]  li;
    logic [63:0] tbits;
    n_valid = 0;
    n_done  = 0;
    n_bad   = 0;
    tbits   = (n == 1) ? 64'(TT1_INIT) : TT6_INIT;
    if (n == 1) ss1 = 1'b1; else ss6 = 1'b1;
    tick();
    ss1 = 1'b0;
    ss6 = 1'b0;
    for (int c = 1; c <= (1 << n) + 2; c++) begin
      @(negedge clk);
      if (n == 1) begin
        lv = ov1; lb = ob1; ld = dn1; lbz = bz1; li = {5'd0, oi1};
      end else begin
        lv = ov6; lb = ob6; ld = dn6; lbz = bz6; li = oi6;
      end
      if (lv !== (c <= (1 << n))) n_bad++;
      if (ld !== (c == (1 << n) + 1)) n_bad++;
      if (lbz !== (c <= (1 << n) + 1)) n_bad++;
      if (lv) begin
        if ((int'(li) != n_valid) || (lb !== tbits[n_valid])) n_bad++;
        n_valid++;
      end
      if (ld) n_done++;
    end
    tick();
    check($sformatf("small%0d_valid_count", n), 64'(n_valid), 64'(1 << n));
    check($sformatf("small%0d_done_count", n), 64'(n_done), 64'd1);
    check($sformatf("small%0d_bad_cycles", n), 64'(n_bad), 64'd0);
  endtask

  initial begin
    tbl[0] = '{3'b110, 1'b1};
    tbl[1] = '{3'b001, 1'b0};
    tbl[2] = '{3'b011, 1'b1};
    tbl[3] = '{3'b111, 1'b1};
    tbl[4] = '{3'b000, 1'b0};
    tbl[5] = '{3'b101, 1'b1};
    tbl[6] = '{3'b100, 1'b0};
    tbl[7] = '{3'b010, 1'b0};

    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_bit = 1'b0; in_valid = 1'b0; sweep_start = 1'b0; in_vec = 3'd0;
    ss1 = 1'b0; ss6 = 1'b0; iv1 = '0; iv6 = '0; tie0 = 1'b0;
    tt_model = TT3_INIT;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_bit", 64'(out_bit), 64'd0);
    check("rst_out_index", 64'(out_index), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // Evaluation against the reset table.
    eval(3'd0);
    eval(3'd7);
    eval(3'd1);
    tick();
    check("eval_idle_valid", 64'(out_valid), 64'd0);

    // Load majority: bits presented 0,0,0,1,0,1,1,1.
    shift_tt(8'b1110_1000);
    tick();

    // Back-to-back evaluations from the vector table.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_vec   = tbl[i].vec;
      sb.push_back('{idx: tbl[i].vec, val: tbl[i].exp_bit});
      tick();
      check($sformatf("tbl_latency_%0d", i), 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("tbl_drain", 64'(sb.size()), 64'd0);

    // Plain sweep, sweep with a colliding eval, sweep with config noise, repeat.
    sweep3(1'b0, 1'b0);
    sweep3(1'b1, 1'b0);
    sweep3(1'b0, 1'b1);
    sweep3(1'b0, 1'b0);

    // Reset while index 4 is on the output.
    sweep_start = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back('{idx: 3'(i), val: tt_model[i]});
    tick();
    sweep_start = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("pre_rst_index", 64'(out_index), 64'd4);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_bit", 64'(out_bit), 64'd0);
    check("midrst_out_index", 64'(out_index), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    sb.delete();
    tt_model = TT3_INIT;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("postrst_done_%0d", c), 64'(done), 64'd0);
      check($sformatf("postrst_busy_%0d", c), 64'(busy), 64'd0);
    end
    @(posedge clk);
    #1;
    sweep3(1'b0, 1'b0);

    // Narrow and wide instances, twice each to exercise the wrap back to 0.
    sweep_small(1);
    sweep_small(1);
    sweep_small(6);
    sweep_small(6);

    check("final_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
